count_checker: RTL and testbench
================================

// Module: count_checker
// PURPOSE
// Synthesizable response checker for the 6-bit BinaryCounter: the observing end
// of the stimulus/monitor pair our generated benches drive. Tracks the counter
// with an internal model, locks onto it, flags every mismatch and queues one
// error record for the bench/host over a valid/ready handshake.
// Also used in-FPGA as a built-in self-check beside the counter.
// PARAMETERS
// WIDTH        6  counter width under check; model wraps modulo 2**WIDTH
// SYNC_CYCLES  2  consecutive correct predictions needed to enter LOCKED (>=1)
// ERRW         8  width of saturating mismatch counter
// PORTS
// clock         in   1      rising-edge clock, same clock as the counter
// reset         in   1      asynchronous, active-low reset
// enable        in   1      counter count-enable, sampled with the counter
// dut_clear     in   1      counter synchronous clear, sampled with the counter
// dut_count     in   WIDTH  counter output under check
// locked        out  1      1 = model aligned, comparisons active
// err_valid     out  1      error record available
// err_ready     in   1      consumer accepts record when err_valid&err_ready
// err_expected  out  WIDTH  model value at the mismatching cycle
// err_observed  out  WIDTH  dut_count at the mismatching cycle
// err_count     out  ERRW   mismatches detected while LOCKED, saturating
// overflow      out  1      sticky: a record was dropped because slot was full
// BEHAVIOUR
// - Reset (reset=0, async): state=ACQUIRE, exp=0, exp_ok=0, match_cnt=0,
//   locked=0, err_valid=0, err_expected=0, err_observed=0, err_count=0,
//   overflow=0. Release is synchronous to next rising edge; reset mid-operation
//   discards any pending record.
// - Prediction: nxt(v) = dut_clear ? 0 : enable ? v+1 (mod 2**WIDTH) : v.
//   dut_clear wins over enable. 2**WIDTH-1 with enable -> 0, not an error.
// - ACQUIRE: every edge exp<=nxt(dut_count), exp_ok<=1. If exp_ok and
//   dut_count==exp, match_cnt++; else match_cnt<=0. When match_cnt would reach
//   SYNC_CYCLES -> LOCKED (locked=1 from that edge). No errors reported here.
// - LOCKED: every edge compare dut_count vs exp.
//   match: exp<=nxt(exp) (model free-runs from its own value, not the DUT).
//   mismatch: record {exp, dut_count} generated; err_count+=1 (hold at
//   2**ERRW-1); state->ACQUIRE, locked=0, match_cnt=0, exp<=nxt(dut_count).
// - Detection latency: mismatch present in cycle n -> err_valid=1 in cycle n+1.
// - Record slot (1 entry): loaded if err_valid=0, or err_valid&err_ready in
//   same cycle (drain+load, err_valid stays 1). Otherwise record dropped,
//   overflow<=1 (sticky until reset), held record unchanged.
// - err_valid stays 1 and err_expected/err_observed stable until accepted;
//   after accept with no new record err_valid=0 next cycle.
// - err_count increments for dropped records too.
// - No combinational path from any input to any output.
// TESTING
// 1 Reset, enable=1 counter from 0: locked=1 after edge 3 (SYNC_CYCLES=2);
//   0x3F->0x00 wrap produces no error, err_count=0.
// 2 Locked at 10, force dut_count=20 for one cycle: next cycle err_valid=1,
//   err_expected=11, err_observed=20, err_count=1, locked=0; relocks after 3.
// 3 err_ready=0, inject two mismatches 4 cycles apart: first record held,
//   overflow=1, err_count=2; err_ready=1 -> one transfer, err_valid=0.
// 4 Record pending, err_ready=1 in same cycle as new mismatch: first drains,
//   second loads, err_valid stays 1, overflow=0.
// 5 Locked, enable=1 and dut_clear=1 together: expected 0; counter giving 0 is
//   clean, counter giving old+1 flags err_expected=0.
// 6 Drop reset mid-run with err_valid=1: all outputs zero immediately
//   (before next edge); 300 mismatches -> err_count saturates at 255.

Source files
------------

// File: rtl/count_checker.sv
// count_checker: response checker for a free-running binary counter.
// A private model of the counter is aligned to the observed count
// (ACQUIRE). It then predicts each value on its own (LOCKED), and every
// disagreement produces one {expected, observed} record. The record sits
// in a single-entry valid/ready slot. All outputs are registered.
module count_checker #(
    parameter int WIDTH       = 6,
    parameter int SYNC_CYCLES = 2,
    parameter int ERRW        = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             dut_clear,
    input  logic [WIDTH-1:0] dut_count,
    output logic             locked,
    output logic             err_valid,
    input  logic             err_ready,
    output logic [WIDTH-1:0] err_expected,
    output logic [WIDTH-1:0] err_observed,
    output logic [ERRW-1:0]  err_count,
    output logic             overflow
);

    localparam int              MW        = $clog2(SYNC_CYCLES + 1);
    localparam logic [MW-1:0]   SYNC_LAST = MW'(SYNC_CYCLES);
    localparam logic [ERRW-1:0] ERR_MAX   = '1;

    typedef enum logic {
        ACQUIRE = 1'b0,
        LOCKED  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] exp_val;
    logic             exp_ok;
    logic [MW-1:0]    match_cnt;

    logic [WIDTH-1:0] pred_dut;
    logic [WIDTH-1:0] pred_exp;
    logic [MW-1:0]    match_inc;
    logic             hit;
    logic             mismatch;
    logic             slot_free;

    // This is the counter's next-state function. A clear has priority
    // over enable. The top value wraps to zero through the truncating add.
    function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] v,
                                             input logic clr,
                                             input logic en);
        if (clr) return '0;
        if (en)  return v + WIDTH'(1);
        return v;
    endfunction

    // This block holds the predictions and the compare result for the current cycle.
    always_comb begin
        // NOTE: every output of an always_comb gets an unconditional value so no latch is inferred.
        pred_dut  = nxt(dut_count, dut_clear, enable);
        pred_exp  = nxt(exp_val, dut_clear, enable);
        match_inc = match_cnt + MW'(1);
        hit       = (dut_count == exp_val);
        mismatch  = (state == LOCKED) && !hit;
        slot_free = !err_valid || err_ready;
    end

    // This block holds the lock FSM, the model register, the error slot and the error counter.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state        <= ACQUIRE;
            exp_val      <= '0;
            exp_ok       <= 1'b0;
            match_cnt    <= '0;
            locked       <= 1'b0;
            err_valid    <= 1'b0;
            err_expected <= '0;
            err_observed <= '0;
            err_count    <= '0;
            overflow     <= 1'b0;
        end else begin
            case (state)
                ACQUIRE: begin
                    // The model follows the observed count until enough
                    // consecutive predictions come true.
                    exp_val <= pred_dut;
                    exp_ok  <= 1'b1;
                    if (exp_ok && hit) begin
                        if (match_inc == SYNC_LAST) begin
                            state     <= LOCKED;
                            locked    <= 1'b1;
                            match_cnt <= '0;
                        end else begin
                            match_cnt <= match_inc;
                        end
                    end else begin
                        match_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        // The model free-runs from its own value. A faulty counter
                        // cannot drag the model along with it.
                        exp_val <= pred_exp;
                    end else begin
                        state     <= ACQUIRE;
                        locked    <= 1'b0;
                        match_cnt <= '0;
                        exp_val   <= pred_dut;
                    end
                end
                default: state <= ACQUIRE;
            endcase

            if (mismatch) begin
                // A new record may replace one that drains in this same cycle.
                // If the slot cannot take it, the existing record is kept.
                if (slot_free) begin
                    err_valid    <= 1'b1;
                    err_expected <= exp_val;
                    err_observed <= dut_count;
                end else begin
                    overflow <= 1'b1;
                end
                if (err_count != ERR_MAX) begin
                    err_count <= err_count + ERRW'(1);
                end
            end else if (err_valid && err_ready) begin
                err_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_count_checker.sv
// Bench for count_checker. It has three parts:
// - a behavioural model of the counter being checked, which can be forced to a wrong value;
// - a scoreboard of the error records expected at the valid/ready port;
// - a vector table for lock-up and first-error timing, plus hand-written corner sequences.
module tb_count_checker;

    localparam int W = 6;
    localparam int E = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable;
    logic         dut_clear;
    logic [W-1:0] dut_count;
    logic         locked;
    logic         err_valid;
    logic         err_ready;
    logic [W-1:0] err_expected;
    logic [W-1:0] err_observed;
    logic [E-1:0] err_count;
    logic         overflow;

    count_checker #(.WIDTH(W), .SYNC_CYCLES(2), .ERRW(E)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .dut_clear    (dut_clear),
        .dut_count    (dut_count),
        .locked       (locked),
        .err_valid    (err_valid),
        .err_ready    (err_ready),
        .err_expected (err_expected),
        .err_observed (err_observed),
        .err_count    (err_count),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [W-1:0] e;
        logic [W-1:0] o;
    } rec_t;

    typedef struct {
        string        name;
        logic         en;
        logic         frc;
        logic [W-1:0] fv;
        logic         rdy;
        logic         push;
        logic [W-1:0] se;
        logic [W-1:0] so;
        logic         x_locked;
        logic         x_valid;
        logic [E-1:0] x_errcnt;
    } vec_t;

    rec_t         sb[$];
    vec_t         vq[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] cnt;
    int           exp_errcnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // This task runs one clock of the counter model. A handshake that is
    // active before the edge retires the oldest scoreboard entry. The
    // outputs are sampled 1 time unit after the edge.
    task automatic tick();
        logic [W-1:0] nc;
        rec_t r;
        nc = dut_clear ? '0 : (enable ? cnt + W'(1) : cnt);
        if (err_valid && err_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_transfer", 32'd1, 32'd0);
            end else begin
                r = sb.pop_front();
                check("sb_err_expected", err_expected, r.e);
                check("sb_err_observed", err_observed, r.o);
            end
        end
        @(posedge clock);
        #1;
        cnt       = nc;
        dut_count = cnt;
    endtask

    task automatic wait_lock(input string name);
        for (int i = 0; i < 10; i++) begin
            if (locked) break;
            tick();
        end
        check(name, locked, 1);
    endtask

    // This task runs one clean locked cycle and then corrupts the next observed value (cnt ^ mask).
    // err_ready is set to rdy for the edge that detects the error.
    task automatic inject(input string name, input logic [W-1:0] mask,
                          input bit push, input logic rdy);
        logic [W-1:0] v;
        tick();
        check({name, "_pre_locked"}, locked, 1);
        v         = cnt ^ mask;
        dut_count = v;
        if (push) sb.push_back('{e: cnt, o: v});
        err_ready = rdy;
        tick();
        if (exp_errcnt < 255) exp_errcnt++;
        check({name, "_locked"}, locked, 0);
        check({name, "_valid"}, err_valid, 1);
        check({name, "_err_count"}, err_count, exp_errcnt);
    endtask

    task automatic add_vec(input string name, input logic en, input logic frc,
                           input logic [W-1:0] fv, input logic rdy, input logic push,
                           input logic [W-1:0] se, input logic [W-1:0] so,
                           input logic xl, input logic xv, input logic [E-1:0] xe);
        vec_t v;
        v.name = name; v.en = en; v.frc = frc; v.fv = fv; v.rdy = rdy;
        v.push = push; v.se = se; v.so = so;
        v.x_locked = xl; v.x_valid = xv; v.x_errcnt = xe;
        vq.push_back(v);
    endtask

    task automatic apply_vec(input vec_t v);
        enable    = v.en;
        dut_clear = 1'b0;
        err_ready = v.rdy;
        tick();
        if (v.frc) dut_count = v.fv;
        if (v.push) sb.push_back('{e: v.se, o: v.so});
        check($sformatf("%s_locked", v.name), locked, v.x_locked);
        check($sformatf("%s_valid", v.name), err_valid, v.x_valid);
        check($sformatf("%s_err_count", v.name), err_count, v.x_errcnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit wrapped;
        int bad;

        // Lock-up timing after reset, hold with enable=0, then the first error with immediate drain.
        add_vec("t1_e1",   1, 0, 0,  0, 0, 0,  0,  0, 0, 0);
        add_vec("t1_e2",   1, 0, 0,  0, 0, 0,  0,  0, 0, 0);
        add_vec("t1_e3",   1, 0, 0,  0, 0, 0,  0,  1, 0, 0);
        add_vec("t1_hold", 0, 0, 0,  0, 0, 0,  0,  1, 0, 0);
        add_vec("t1_hold", 0, 0, 0,  0, 0, 0,  0,  1, 0, 0);
        add_vec("t1_run",  1, 0, 0,  0, 0, 0,  0,  1, 0, 0);
        add_vec("t2_frc",  1, 1, 20, 1, 1, 11, 20, 1, 0, 0);
        add_vec("t2_det",  1, 0, 0,  1, 0, 0,  0,  0, 1, 1);
        add_vec("t2_acc",  1, 0, 0,  1, 0, 0,  0,  0, 0, 1);
        add_vec("t2_m1",   1, 0, 0,  1, 0, 0,  0,  0, 0, 1);
        add_vec("t2_lock", 1, 0, 0,  1, 0, 0,  0,  1, 0, 1);

        reset      = 1'b0;
        enable     = 1'b0;
        dut_clear  = 1'b0;
        err_ready  = 1'b0;
        dut_count  = '0;
        cnt        = '0;
        exp_errcnt = 0;
        #3;
        check("rst_locked", locked, 0);
        check("rst_valid", err_valid, 0);
        check("rst_expected", err_expected, 0);
        check("rst_observed", err_observed, 0);
        check("rst_err_count", err_count, 0);
        check("rst_overflow", overflow, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Test 1: lock after edge 3, stay locked through the 0x3F->0x00 wrap.
        for (int i = 0; i < 6; i++) apply_vec(vq[i]);
        wrapped = 0;
        bad     = 0;
        enable  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (cnt == 0) wrapped = 1;
            if (!locked || err_valid) bad++;
            if (wrapped && cnt == 10) break;
        end
        check("t1_wrap_reached", (wrapped && cnt == 10), 1);
        check("t1_clean_cycles", bad, 0);
        check("t1_err_count", err_count, 0);

        // Test 2: at count 10, force 20 where 11 is due. A record {11,20} is expected, then relock after 3 edges.
        for (int i = 6; i < 11; i++) apply_vec(vq[i]);
        exp_errcnt = 1;
        enable     = 1'b1;
        err_ready  = 1'b0;

        // Test 4: a held record drains in the same cycle that a new one loads.
        inject("t4_a", 6'h2A, 1, 1'b0);
        wait_lock("t4_relock");
        check("t4_held_valid", err_valid, 1);
        inject("t4_b", 6'h15, 1, 1'b1);
        check("t4_new_observed", err_observed, sb[0].o);
        check("t4_new_expected", err_expected, sb[0].e);
        check("t4_no_overflow", overflow, 0);
        tick();
        check("t4_drained", err_valid, 0);
        err_ready = 1'b0;

        // Test 3: slot full, a second mismatch 4 edges later is dropped, and overflow becomes sticky.
        wait_lock("t3_lock");
        inject("t3_a", 6'h3C, 1, 1'b0);
        tick();
        tick();
        inject("t3_b", 6'h07, 0, 1'b0);
        check("t3_overflow", overflow, 1);
        check("t3_held_expected", err_expected, sb[0].e);
        check("t3_held_observed", err_observed, sb[0].o);
        err_ready = 1'b1;
        tick();
        check("t3_accepted", err_valid, 0);
        check("t3_sb_empty", sb.size(), 0);
        tick();
        check("t3_overflow_sticky", overflow, 1);
        err_ready = 1'b0;

        // Test 5: clear and enable together predict 0.
        wait_lock("t5_lock");
        dut_clear = 1'b1;
        tick();
        dut_clear = 1'b0;
        tick();
        check("t5_clean_locked", locked, 1);
        check("t5_clean_valid", err_valid, 0);
        check("t5_clean_err_count", err_count, exp_errcnt);
        dut_clear = 1'b1;
        begin
            logic [W-1:0] old;
            old = cnt;
            tick();
            dut_count = old + W'(1);
            sb.push_back('{e: '0, o: old + W'(1)});
        end
        dut_clear = 1'b0;
        err_ready = 1'b1;
        tick();
        if (exp_errcnt < 255) exp_errcnt++;
        check("t5_bad_valid", err_valid, 1);
        check("t5_bad_expected", err_expected, 0);
        check("t5_bad_err_count", err_count, exp_errcnt);
        tick();
        check("t5_drained", err_valid, 0);
        err_ready = 1'b0;

        // Test 6: asynchronous reset while a record is pending, then saturation of err_count.
        wait_lock("t6_lock");
        inject("t6_pend", 6'h11, 1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_locked", locked, 0);
        check("t6_rst_valid", err_valid, 0);
        check("t6_rst_expected", err_expected, 0);
        check("t6_rst_observed", err_observed, 0);
        check("t6_rst_err_count", err_count, 0);
        check("t6_rst_overflow", overflow, 0);
        sb.delete();
        exp_errcnt = 0;
        @(negedge clock);
        cnt       = '0;
        dut_count = '0;
        enable    = 1'b1;
        dut_clear = 1'b0;
        err_ready = 1'b1;
        reset     = 1'b1;
        for (int i = 0; i < 300; i++) begin
            wait_lock("t6_relock");
            inject("t6_sat", W'(i % 63 + 1), 1, 1'b1);
            if (i == 254) check("t6_at_255", err_count, 255);
        end
        tick();
        tick();
        check("t6_saturated", err_count, 255);
        check("t6_no_overflow", overflow, 0);
        check("t6_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
